// File: rtl/reg_pkg.sv
// Shared constants and register names for multi_port_register_file.
// The default widths of the register file come from here.
package reg_pkg;

  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned BYTE_W    = 8;

  // Architectural register names; one entry per register.
  typedef enum logic [3:0] {
    R0, R1, R2, R3, R4, R5, R6, R7,
    R8, R9, R10, R11, R12, R13, R14, R15
  } reg_e;

  // Select width for n registers, never narrower than one bit.
  function automatic int unsigned sel_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_port_register_file_if.sv
// Control/datapath bus of the register file: read ports, ALU write, reserve and
// write-back strobes, plus scoreboard status. The tri-stated read data stays a
// plain port of the register file.
interface multi_port_register_file_if #(
  parameter int unsigned WIDTH    = reg_pkg::REG_WIDTH,
  parameter int unsigned NUM_REGS = reg_pkg::NUM_REGS,
  parameter int unsigned NUM_RD   = 2
);
  localparam int unsigned SEL_W = reg_pkg::sel_width(NUM_REGS);

  logic [NUM_RD-1:0][SEL_W-1:0] rd_sel;
  logic [NUM_RD-1:0]            rd_oe;
  logic [NUM_RD-1:0]            rd_stall;
  logic                         wr_ld;
  logic [SEL_W-1:0]             wr_sel;
  logic [WIDTH-1:0]             wr_data;
  logic [WIDTH/8-1:0]           wr_be;
  logic                         rsv_ld;
  logic [SEL_W-1:0]             rsv_sel;
  logic                         wb_ld;
  logic [SEL_W-1:0]             wb_sel;
  logic [WIDTH-1:0]             wb_data;
  logic [NUM_REGS-1:0]          busy;
  logic                         hazard;

  modport master (
    output rd_sel, rd_oe, wr_ld, wr_sel, wr_data, wr_be,
    output rsv_ld, rsv_sel, wb_ld, wb_sel, wb_data,
    input  rd_stall, busy, hazard
  );

  modport slave (
    input  rd_sel, rd_oe, wr_ld, wr_sel, wr_data, wr_be,
    input  rsv_ld, rsv_sel, wb_ld, wb_sel, wb_data,
    output rd_stall, busy, hazard
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one bit per register, set by a reservation and cleared by
// write-back, plus a registered hazard flag for ALU writes to busy registers.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = reg_pkg::NUM_REGS,
  parameter int unsigned SEL_W    = reg_pkg::sel_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rsv_ld,
  input  logic [SEL_W-1:0]    rsv_sel,
  input  logic                wb_ld,
  input  logic [SEL_W-1:0]    wb_sel,
  input  logic                wr_ld,
  input  logic [SEL_W-1:0]    wr_sel,
  output logic [NUM_REGS-1:0] busy,
  output logic                hazard
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                hazard_q, hazard_d;

  // Next busy state; a reservation outranks a same-edge write-back clear.
  // Out-of-range selects match no register and change nothing.
  always_comb begin
    busy_d   = busy_q;
    hazard_d = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (wb_ld && (wb_sel == SEL_W'(r))) busy_d[r] = 1'b0;
      if (rsv_ld && (rsv_sel == SEL_W'(r))) busy_d[r] = 1'b1;
      if (wr_ld && (wr_sel == SEL_W'(r)) && busy_q[r]) hazard_d = 1'b1;
    end
  end

  // Scoreboard and hazard flops; reset drops all outstanding reservations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      hazard_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      hazard_q <= hazard_d;
    end
  end

  assign busy   = busy_q;
  assign hazard = hazard_q;

endmodule

// File: rtl/multi_port_register_file.sv
// Parametrised register file: NUM_RD tri-stated read ports, a byte-enabled ALU
// write port and a full-word write-back port, with a busy scoreboard that
// stalls reads of registers whose write-back is outstanding.
// Optional feature: define MULTI_PORT_REGISTER_FILE_BYPASS_EN to forward
// same-cycle write-back data to matching read ports.
module multi_port_register_file #(
  parameter int unsigned WIDTH    = reg_pkg::REG_WIDTH,
  parameter int unsigned NUM_REGS = reg_pkg::NUM_REGS,
  parameter int unsigned NUM_RD   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  multi_port_register_file_if.slave  bus,
  output wire [NUM_RD*WIDTH-1:0]     rd_data
);

  localparam int unsigned SEL_W  = reg_pkg::sel_width(NUM_REGS);
  localparam int unsigned BYTE_W = reg_pkg::BYTE_W;
  localparam int unsigned NBYTES = WIDTH / BYTE_W;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            busy;
  logic [NUM_RD-1:0][WIDTH-1:0]   rd_val;
  logic [NUM_RD-1:0]              stall;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .rsv_ld  (bus.rsv_ld),
    .rsv_sel (bus.rsv_sel),
    .wb_ld   (bus.wb_ld),
    .wb_sel  (bus.wb_sel),
    .wr_ld   (bus.wr_ld),
    .wr_sel  (bus.wr_sel),
    .busy    (busy),
    .hazard  (bus.hazard)
  );

  assign bus.busy = busy;

  // Storage next state; write-back takes the whole word and drops a same-edge
  // ALU write to the same register.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (bus.wb_ld && (bus.wb_sel == SEL_W'(r))) begin
        regs_d[r] = bus.wb_data;
      end else if (bus.wr_ld && (bus.wr_sel == SEL_W'(r))) begin
        for (int unsigned b = 0; b < NBYTES; b++) begin
          if (bus.wr_be[b]) regs_d[r][b*BYTE_W +: BYTE_W] = bus.wr_data[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Register storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes and stall; a select matching no register reads 0 and never stalls.
  always_comb begin
    rd_val = '0;
    stall  = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (bus.rd_sel[i] == SEL_W'(r)) begin
          rd_val[i] = regs_q[r];
          stall[i]  = busy[r];
`ifdef MULTI_PORT_REGISTER_FILE_BYPASS_EN
          if (bus.wb_ld && (bus.wb_sel == SEL_W'(r))) begin
            rd_val[i] = bus.wb_data;
            stall[i]  = 1'b0;
          end
`endif
        end
      end
      stall[i] = stall[i] & bus.rd_oe[i];
    end
  end

  assign bus.rd_stall = stall;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_drv
    assign rd_data[i*WIDTH +: WIDTH] = bus.rd_oe[i] ? rd_val[i] : {WIDTH{1'bz}};
  end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Self-checking bench for multi_port_register_file: a table of per-cycle
// vectors checked through an expectation queue, then a hand-written sequence
// for the hazard pulse and the asynchronous mid-cycle reset.
module tb_multi_port_register_file;
  import reg_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned NR = 16;
  localparam int unsigned RD = 2;

`ifdef MULTI_PORT_REGISTER_FILE_BYPASS_EN
  localparam logic [31:0] BYP_RD = 32'd321;
  localparam logic [1:0]  BYP_ST = 2'b00;
`else
  localparam logic [31:0] BYP_RD = 32'd7;
  localparam logic [1:0]  BYP_ST = 2'b01;
`endif

  typedef struct {
    logic        wr_ld;
    logic [3:0]  wr_sel;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rsv_ld;
    logic [3:0]  rsv_sel;
    logic        wb_ld;
    logic [3:0]  wb_sel;
    logic [31:0] wb_data;
    logic [3:0]  sel0;
    logic [3:0]  sel1;
    logic [1:0]  oe;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [15:0] exp_busy;
    logic [1:0]  exp_stall;
    logic        exp_hazard;
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  oe;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [15:0] exp_busy;
    logic [1:0]  exp_stall;
    logic        exp_hazard;
  } exp_t;

  localparam int NV = 18;

  logic clk;
  logic rst;
  wire [RD*W-1:0] rd_data;

  multi_port_register_file_if #(.WIDTH(W), .NUM_REGS(NR), .NUM_RD(RD)) bus ();

  multi_port_register_file #(
    .WIDTH    (W),
    .NUM_REGS (NR),
    .NUM_RD   (RD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[NV];
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_z(input string name, input logic [31:0] act);
    logic [31:0] zz;
    zz = 'z;
    n_cmp++;
    if (act !== zz) begin
      n_err++;
      $display("FAIL %s: got %h, want high-Z", name, act);
    end
  endtask

  task automatic idle();
    bus.wr_ld   = 1'b0;
    bus.wr_sel  = '0;
    bus.wr_data = '0;
    bus.wr_be   = '0;
    bus.rsv_ld  = 1'b0;
    bus.rsv_sel = '0;
    bus.wb_ld   = 1'b0;
    bus.wb_sel  = '0;
    bus.wb_data = '0;
    bus.rd_sel  = '0;
    bus.rd_oe   = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.wr_ld     = v.wr_ld;
    bus.wr_sel    = v.wr_sel;
    bus.wr_data   = v.wr_data;
    bus.wr_be     = v.wr_be;
    bus.rsv_ld    = v.rsv_ld;
    bus.rsv_sel   = v.rsv_sel;
    bus.wb_ld     = v.wb_ld;
    bus.wb_sel    = v.wb_sel;
    bus.wb_data   = v.wb_data;
    bus.rd_sel[0] = v.sel0;
    bus.rd_sel[1] = v.sel1;
    bus.rd_oe     = v.oe;
  endtask

  task automatic check_port(input string name, input logic oe, input logic [31:0] act,
                            input logic [31:0] exp);
    if (oe) chk(name, act, exp);
    else    chk_z(name, act);
  endtask

  initial begin
    exp_t e;
    // Each row: inputs held for one cycle; expectations are what the outputs
    // show during that cycle, before its own edge takes effect.
    //            wr_ld sel  data          be       rsv sel  wb sel  data
    //            rd0 rd1 oe     exp0          exp1          busy     stall  hz
    vecs[0]  = '{1'b0, R0, 32'h0,        4'h0,    1'b0, R0, 1'b0, R0, 32'h0,
                 R3, R3, 2'b11, 32'h0,        32'h0,        16'h0000, 2'b00, 1'b0};
    vecs[1]  = '{1'b1, R3, 32'hDEADBEEF, 4'hF,    1'b0, R0, 1'b0, R0, 32'h0,
                 R3, R3, 2'b11, 32'h0,        32'h0,        16'h0000, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, R0, 32'h0,        4'h0,    1'b0, R0, 1'b0, R0, 32'h0,
                 R3, R3, 2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 16'h0000, 2'b00, 1'b0};
    vecs[3]  = '{1'b1, R3, 32'h11223344, 4'b0101, 1'b0, R0, 1'b0, R0, 32'h0,
                 R3, R3, 2'b00, 32'h0,        32'h0,        16'h0000, 2'b00, 1'b0};
    vecs[4]  = '{1'b0, R0, 32'h0,        4'h0,    1'b0, R0, 1'b0, R0, 32'h0,
                 R3, R3, 2'b01, 32'hDE22BE44, 32'h0,        16'h0000, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, R0, 32'h0,        4'h0,    1'b1, R5, 1'b0, R0, 32'h0,
                 R5, R3, 2'b11, 32'h0,        32'hDE22BE44, 16'h0000, 2'b00, 1'b0};
    vecs[6]  = '{1'b0, R0, 32'h0,        4'h0,    1'b0, R0, 1'b0, R0, 32'h0,
                 R5, R5, 2'b01, 32'h0,        32'h0,        16'h0020, 2'b01, 1'b0};
    vecs[7]  = '{1'b0, R0, 32'h0,        4'h0,    1'b0, R0, 1'b1, R5, 32'd567,
                 R4, R4, 2'b01, 32'h0,        32'h0,        16'h0020, 2'b00, 1'b0};
    vecs[8]  = '{1'b0, R0, 32'h0,        4'h0,    1'b1, R5, 1'b1, R5, 32'd7,
                 R3, R3, 2'b11, 32'hDE22BE44, 32'hDE22BE44, 16'h0000, 2'b00, 1'b0};
    vecs[9]  = '{1'b1, R2, 32'd1,        4'hF,    1'b0, R0, 1'b1, R2, 32'd2,
                 R5, R5, 2'b11, 32'd7,        32'd7,        16'h0020, 2'b11, 1'b0};
    vecs[10] = '{1'b0, R0, 32'h0,        4'h0,    1'b1, R6, 1'b0, R0, 32'h0,
                 R2, R5, 2'b11, 32'd2,        32'd7,        16'h0020, 2'b10, 1'b0};
    vecs[11] = '{1'b1, R6, 32'd9,        4'hF,    1'b0, R0, 1'b0, R0, 32'h0,
                 R6, R6, 2'b01, 32'h0,        32'h0,        16'h0060, 2'b01, 1'b0};
    vecs[12] = '{1'b1, R7, 32'hFFFFFFFF, 4'h0,    1'b0, R0, 1'b0, R0, 32'h0,
                 R6, R6, 2'b01, 32'd9,        32'h0,        16'h0060, 2'b01, 1'b1};
    vecs[13] = '{1'b0, R0, 32'h0,        4'h0,    1'b0, R0, 1'b1, R6, 32'hA,
                 R7, R3, 2'b11, 32'h0,        32'hDE22BE44, 16'h0060, 2'b00, 1'b0};
    vecs[14] = '{1'b0, R0, 32'h0,        4'h0,    1'b0, R0, 1'b1, R5, 32'd321,
                 R5, R5, 2'b01, BYP_RD,       32'h0,        16'h0020, BYP_ST, 1'b0};
    vecs[15] = '{1'b0, R0, 32'h0,        4'h0,    1'b1, R2, 1'b0, R0, 32'h0,
                 R5, R6, 2'b11, 32'd321,      32'hA,        16'h0000, 2'b00, 1'b0};
    vecs[16] = '{1'b0, R0, 32'h0,        4'h0,    1'b1, R5, 1'b0, R0, 32'h0,
                 R2, R2, 2'b01, 32'd2,        32'h0,        16'h0004, 2'b01, 1'b0};
    vecs[17] = '{1'b0, R0, 32'h0,        4'h0,    1'b0, R0, 1'b0, R0, 32'h0,
                 R2, R5, 2'b11, 32'd2,        32'd321,      16'h0024, 2'b11, 1'b0};

    idle();
    rst = 1'b0;
    #12 rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      q.push_back('{i, vecs[i].oe, vecs[i].exp0, vecs[i].exp1, vecs[i].exp_busy,
                    vecs[i].exp_stall, vecs[i].exp_hazard});
      @(negedge clk);
      e = q.pop_front();
      check_port($sformatf("v%0d rd0", e.idx), e.oe[0], rd_data[31:0], e.exp0);
      check_port($sformatf("v%0d rd1", e.idx), e.oe[1], rd_data[63:32], e.exp1);
      chk($sformatf("v%0d busy", e.idx), 32'(bus.busy), 32'(e.exp_busy));
      chk($sformatf("v%0d stall", e.idx), 32'(bus.rd_stall), 32'(e.exp_stall));
      chk($sformatf("v%0d hazard", e.idx), 32'(bus.hazard), 32'(e.exp_hazard));
    end

    // ALU write to busy R2 raises hazard, then reset lands mid-cycle.
    @(posedge clk);
    #1;
    idle();
    bus.wr_ld     = 1'b1;
    bus.wr_sel    = R2;
    bus.wr_data   = 32'h77;
    bus.wr_be     = 4'hF;
    bus.rd_sel[0] = R2;
    bus.rd_sel[1] = R5;
    bus.rd_oe     = 2'b11;
    @(posedge clk);
    #1;
    bus.wr_ld = 1'b0;
    chk("hazard before reset", 32'(bus.hazard), 32'd1);
    chk("r2 before reset", rd_data[31:0], 32'h77);
    chk("busy before reset", 32'(bus.busy), 32'h0024);
    #2 rst = 1'b0;
    #1;
    chk("busy in reset", 32'(bus.busy), 32'h0);
    chk("hazard in reset", 32'(bus.hazard), 32'h0);
    chk("r2 in reset", rd_data[31:0], 32'h0);
    chk("r5 in reset", rd_data[63:32], 32'h0);
    chk("stall in reset", 32'(bus.rd_stall), 32'h0);
    #1 rst = 1'b1;

    // Write-back after reset finds no busy bit and writes normally.
    @(posedge clk);
    #1;
    bus.wb_ld   = 1'b1;
    bus.wb_sel  = R5;
    bus.wb_data = 32'h55;
    bus.rd_sel[0] = R3;
    @(posedge clk);
    #1;
    bus.wb_ld = 1'b0;
    chk("busy after wb", 32'(bus.busy), 32'h0);
    chk("r5 after wb", rd_data[63:32], 32'h55);
    chk("r3 after reset", rd_data[31:0], 32'h0);
    chk("stall after wb", 32'(bus.rd_stall), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
